multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Parametrised multi-cycle MIPS control unit. It is the sequential successor to the single-cycle combinational Control decoder. A Moore FSM sequences Fetch/Decode/Execute/Memory/Writeback over several clocks. It supports the same opcode set plus ADDI and illegal-opcode trapping, waits on a memory-ready handshake, and counts retired instructions. It drives the multi-cycle datapath: PC, IR, ALU muxes, memory and register file.

Parameters:
OPCODE_W, 6, opcode field width; opcode constants are sized to it.
CNT_W, 16, width of the retired-instruction counter.
WAIT_MEM, 1, 1 = memory states stall until MemReady; 0 = memory always completes in one cycle and MemReady is ignored.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
Opcode  in  OPCODE_W  IR[31:26], valid from DECODE onward.
MemReady  in  1  memory access complete this cycle.
PCWrite  out  1  unconditional PC load.
PCWriteCond  out  1  conditional PC load on branch.
BNE  out  1  1 = branch on not-zero, 0 = branch on zero (with PCWriteCond).
IorD  out  1  0 = PC address, 1 = ALUOut address.
MemRead  out  1  memory read strobe.
MemWrite  out  1  memory write strobe.
IRWrite  out  1  IR load.
MemToReg  out  1  writeback data select: 1 = MDR.
RegDst  out  1  1 = rd, 0 = rt.
RegWrite  out  1  register file write.
ALUSrcA  out  1  0 = PC, 1 = A.
ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm shifted left 2.
ALUop  out  2  00 = add, 01 = sub, 10 = funct.
PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
Illegal  out  1  one-cycle pulse on an undefined opcode.
State  out  4  current state encoding, for debug.
InstrCount  out  CNT_W  retired instructions.

Behaviour:
- Moore outputs: every control output is a pure decode of the state register; there is no Opcode→output combinational path.
- Any output not listed for a state is 0 in that state.
- Reset (rst_n=0, asynchronous):
  - State = RESET (0).
  - All outputs 0.
  - InstrCount = 0.
- Reset asserted mid-instruction aborts immediately; there are no partial writes after the reset edge.
- States and transitions:
  - RESET → FETCH unconditionally. All outputs 0.
  - FETCH:
    - Outputs: MemRead=1, IRWrite=1, ALUSrcB=01, PCWrite=1.
    - IRWrite and PCWrite are gated by MemReady when WAIT_MEM=1.
    - Next state: DECODE when ready, otherwise stay in FETCH.
  - DECODE:
    - Outputs: ALUSrcB=11.
    - Next state by Opcode:
      - 000000 → RTYPE_EX
      - 100011 or 101011 → MEM_ADDR
      - 000100 or 000101 → BRANCH
      - 000010 → JUMP
      - 001000 → ADDI_EX
      - any other opcode → ILLEGAL
  - MEM_ADDR:
    - Outputs: ALUSrcA=1, ALUSrcB=10.
    - Next state: MEM_RD for lw, MEM_WR for sw.
  - MEM_RD:
    - Outputs: MemRead=1, IorD=1.
    - Next state: WB_MEM when ready, otherwise stay.
  - WB_MEM:
    - Outputs: RegWrite=1, MemToReg=1, RegDst=0.
    - Retires; next state FETCH.
  - MEM_WR:
    - Outputs: MemWrite=1, IorD=1.
    - Retires when ready; next state FETCH. Otherwise hold with MemWrite=1.
  - RTYPE_EX:
    - Outputs: ALUSrcA=1, ALUop=10.
    - Next state: RTYPE_WB.
  - RTYPE_WB:
    - Outputs: RegWrite=1, RegDst=1.
    - Retires; next state FETCH.
  - ADDI_EX:
    - Outputs: ALUSrcA=1, ALUSrcB=10, ALUop=00.
    - Next state: ADDI_WB.
  - ADDI_WB:
    - Outputs: RegWrite=1, RegDst=0, MemToReg=0.
    - Retires; next state FETCH.
  - BRANCH:
    - Outputs: ALUSrcA=1, ALUop=01, PCWriteCond=1, PCSource=01, BNE=Opcode[0].
    - Retires; next state FETCH.
  - JUMP:
    - Outputs: PCWrite=1, PCSource=10.
    - Retires; next state FETCH.
  - ILLEGAL:
    - Outputs: Illegal=1.
    - Next state FETCH. Does not retire; no register or memory write.
- "ready" = MemReady when WAIT_MEM=1, and constant 1 when WAIT_MEM=0.
- InstrCount:
  - Increments by 1 on the clock edge leaving a retiring state.
  - Saturates at 2^CNT_W−1; it does not wrap.
- Latency in cycles with no wait states:
  - lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 3.
  - Each MemReady=0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Opcode changes outside DECODE and MEM_ADDR are ignored.

Test Plan:
- Reset then R-type: rst_n low 2 cycles, release, Opcode=000000, MemReady=1.
  - Required states: RESET, FETCH, DECODE, RTYPE_EX, RTYPE_WB, FETCH.
  - RegWrite=1 and RegDst=1 only in RTYPE_WB; InstrCount=1.
- lw with 2 wait cycles: Opcode=100011, MemReady=0 for 2 cycles in MEM_RD.
  - MEM_RD held 3 cycles with MemRead=1 and IorD=1.
  - WB_MEM asserts RegWrite=1 and MemToReg=1; total 7 cycles.
- Branches: Opcode=000100, then 000101.
  - BRANCH state asserts PCWriteCond=1, ALUop=01, PCSource=01.
  - BNE=0, then BNE=1; each instruction 3 cycles.
- Jump and addi: Opcode=000010 → PCWrite=1, PCSource=10, 3 cycles. Opcode=001000 → ADDI_WB asserts RegWrite=1, RegDst=0.
- Illegal: Opcode=111111.
  - Illegal=1 for exactly 1 cycle.
  - No RegWrite, MemWrite or PC write after DECODE.
  - InstrCount unchanged.
- Async reset mid-sw and saturation:
  - Drop rst_n while in MEM_WR with MemReady=0 → outputs 0 before the next clk edge, State=0.
  - With CNT_W=2, retire 5 instructions → InstrCount=3.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with memory-ready stalls, illegal-opcode trapping and a saturating retired-instruction counter.
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 16,
    parameter bit WAIT_MEM = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                BNE,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemToReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUop,
    output logic [1:0]          PCSource,
    output logic                Illegal,
    output logic [3:0]          State,
    output logic [CNT_W-1:0]    InstrCount
);

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_WB_MEM   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    state_t             state_q, state_d;
    logic               bne_q, bne_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready;
    logic               retire;

    assign ready = WAIT_MEM ? MemReady : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            bne_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            bne_q   <= bne_d;
            count_q <= count_d;
        end
    end

    // Branch sense is captured in DECODE so later Opcode changes cannot affect BRANCH.
    always_comb begin
        state_d = state_q;
        bne_d   = bne_q;
        retire  = 1'b0;
        case (state_q)
            S_RESET:    state_d = S_FETCH;
            S_FETCH:    if (ready) state_d = S_DECODE;
            S_DECODE: begin
                bne_d = Opcode[0];
                if (Opcode == OP_RTYPE)                      state_d = S_RTYPE_EX;
                else if (Opcode == OP_LW || Opcode == OP_SW) state_d = S_MEM_ADDR;
                else if (Opcode == OP_BEQ || Opcode == OP_BNE) state_d = S_BRANCH;
                else if (Opcode == OP_J)                     state_d = S_JUMP;
                else if (Opcode == OP_ADDI)                  state_d = S_ADDI_EX;
                else                                         state_d = S_ILLEGAL;
            end
            S_MEM_ADDR: state_d = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (ready) state_d = S_WB_MEM;
            S_MEM_WR: begin
                if (ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_WB_MEM, S_RTYPE_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ILLEGAL:  state_d = S_FETCH;
            default:    state_d = S_RESET;
        endcase
        count_d = (retire && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BNE         = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUop       = 2'b00;
        PCSource    = 2'b00;
        Illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = ready;
                PCWrite = ready;
                ALUSrcB = 2'b01;
            end
            S_DECODE:   ALUSrcB = 2'b11;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_RTYPE_EX: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b10;
            end
            S_RTYPE_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDI_WB:  RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BNE         = bne_q;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ILLEGAL:  Illegal = 1'b1;
            default: ;
        endcase
    end

    assign State      = state_q;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected state/controls/counts go through
// a scoreboard queue and are compared against a default instance and a 2-bit-counter instance.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] Opcode = 6'd0;
    logic       MemReady = 1'b1;

    logic        PCWrite, PCWriteCond, BNE, IorD, MemRead, MemWrite, IRWrite;
    logic        MemToReg, RegDst, RegWrite, ALUSrcA, Illegal;
    logic [1:0]  ALUSrcB, ALUop, PCSource;
    logic [3:0]  State;
    logic [15:0] InstrCount;

    logic        s_PCWrite, s_PCWriteCond, s_BNE, s_IorD, s_MemRead, s_MemWrite, s_IRWrite;
    logic        s_MemToReg, s_RegDst, s_RegWrite, s_ALUSrcA, s_Illegal;
    logic [1:0]  s_ALUSrcB, s_ALUop, s_PCSource;
    logic [3:0]  s_State;
    logic [1:0]  s_InstrCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BNE(BNE), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUop(ALUop), .PCSource(PCSource), .Illegal(Illegal), .State(State),
        .InstrCount(InstrCount)
    );

    multicycle_control #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(s_PCWrite), .PCWriteCond(s_PCWriteCond), .BNE(s_BNE), .IorD(s_IorD),
        .MemRead(s_MemRead), .MemWrite(s_MemWrite), .IRWrite(s_IRWrite), .MemToReg(s_MemToReg),
        .RegDst(s_RegDst), .RegWrite(s_RegWrite), .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB),
        .ALUop(s_ALUop), .PCSource(s_PCSource), .Illegal(s_Illegal), .State(s_State),
        .InstrCount(s_InstrCount)
    );

    localparam logic [3:0] ST_RESET = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_MEM_ADDR = 4'd3,
                           ST_MEM_RD = 4'd4, ST_WB_MEM = 4'd5, ST_MEM_WR = 4'd6, ST_RTYPE_EX = 4'd7,
                           ST_RTYPE_WB = 4'd8, ST_ADDI_EX = 4'd9, ST_ADDI_WB = 4'd10,
                           ST_BRANCH = 4'd11, ST_JUMP = 4'd12, ST_ILLEGAL = 4'd13;

    // Control vector: PCWrite,PCWriteCond,BNE,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUop,PCSource,Illegal
    localparam logic [17:0] C_NONE   = 18'b0;
    localparam logic [17:0] C_FETCH  = {11'b1000101_0000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] C_FWAIT  = {11'b0000100_0000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] C_DECODE = {11'b0000000_0000, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] C_MADDR  = {11'b0000000_0001, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] C_MEMRD  = {11'b0001100_0000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] C_WBMEM  = {11'b0000000_1010, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] C_MEMWR  = {11'b0001010_0000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] C_RTEX   = {11'b0000000_0001, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [17:0] C_RTWB   = {11'b0000000_0110, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] C_ADDIEX = {11'b0000000_0001, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] C_ADDIWB = {11'b0000000_0010, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [17:0] C_BEQ    = {11'b0100000_0001, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [17:0] C_BNE    = {11'b0110000_0001, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [17:0] C_JUMP   = {11'b1000000_0000, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [17:0] C_ILL    = {11'b0000000_0000, 2'b00, 2'b00, 2'b00, 1'b1};

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                           OP_ADDI = 6'b001000, OP_BAD = 6'b111111;

    typedef struct packed {
        logic [3:0]  state;
        logic [17:0] ctrl;
        logic [15:0] cnt;
        logic [1:0]  sat;
    } exp_t;

    exp_t scoreboard[$];

    wire [17:0] obs_ctrl = {PCWrite, PCWriteCond, BNE, IorD, MemRead, MemWrite, IRWrite,
                            MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, Illegal};
    wire [17:0] obs_sat_ctrl = {s_PCWrite, s_PCWriteCond, s_BNE, s_IorD, s_MemRead, s_MemWrite,
                                s_IRWrite, s_MemToReg, s_RegDst, s_RegWrite, s_ALUSrcA, s_ALUSrcB,
                                s_ALUop, s_PCSource, s_Illegal};

    task automatic push_expected(input logic [3:0] st, input logic [17:0] ctrl, input int cnt);
        exp_t e;
        e.state = st;
        e.ctrl  = ctrl;
        e.cnt   = 16'(cnt);
        e.sat   = (cnt > 3) ? 2'd3 : 2'(cnt);
        scoreboard.push_back(e);
    endtask

    task automatic check_output(input string tag);
        exp_t e;
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty", tag);
            return;
        end
        e = scoreboard.pop_front();
        checks++;
        assert (State === e.state) else begin
            errors++;
            $error("FAIL %s.state observed %0d expected %0d", tag, State, e.state);
        end
        checks++;
        assert (obs_ctrl === e.ctrl) else begin
            errors++;
            $error("FAIL %s.ctrl observed %b expected %b", tag, obs_ctrl, e.ctrl);
        end
        checks++;
        assert (InstrCount === e.cnt) else begin
            errors++;
            $error("FAIL %s.count observed %0d expected %0d", tag, InstrCount, e.cnt);
        end
        checks++;
        assert ({s_State, obs_sat_ctrl} === {e.state, e.ctrl}) else begin
            errors++;
            $error("FAIL %s.sat_ctrl observed %0d/%b expected %0d/%b", tag, s_State,
                   obs_sat_ctrl, e.state, e.ctrl);
        end
        checks++;
        assert (s_InstrCount === e.sat) else begin
            errors++;
            $error("FAIL %s.sat_count observed %0d expected %0d", tag, s_InstrCount, e.sat);
        end
    endtask

    // One cycle: drive inputs at the falling edge, check mid-low-phase, advance to next falling edge.
    task automatic apply_stimulus(input string tag, input logic [5:0] op, input logic rdy,
                                  input logic [3:0] st, input logic [17:0] ctrl, input int cnt);
        Opcode   = op;
        MemReady = rdy;
        push_expected(st, ctrl, cnt);
        #1;
        check_output(tag);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        apply_stimulus("reset0", OP_R, 1'b1, ST_RESET, C_NONE, 0);
        apply_stimulus("reset1", OP_R, 1'b1, ST_RESET, C_NONE, 0);
        rst_n = 1'b1;

        apply_stimulus("r.reset", OP_R, 1'b1, ST_RESET,    C_NONE,   0);
        apply_stimulus("r.fetch", OP_R, 1'b1, ST_FETCH,    C_FETCH,  0);
        apply_stimulus("r.dec",   OP_R, 1'b1, ST_DECODE,   C_DECODE, 0);
        apply_stimulus("r.ex",    OP_R, 1'b1, ST_RTYPE_EX, C_RTEX,   0);
        apply_stimulus("r.wb",    OP_R, 1'b1, ST_RTYPE_WB, C_RTWB,   0);

        apply_stimulus("lw.fetch", OP_LW, 1'b1, ST_FETCH,    C_FETCH,  1);
        apply_stimulus("lw.dec",   OP_LW, 1'b1, ST_DECODE,   C_DECODE, 1);
        apply_stimulus("lw.addr",  OP_LW, 1'b1, ST_MEM_ADDR, C_MADDR,  1);
        apply_stimulus("lw.rd0",   OP_LW, 1'b0, ST_MEM_RD,   C_MEMRD,  1);
        apply_stimulus("lw.rd1",   OP_LW, 1'b0, ST_MEM_RD,   C_MEMRD,  1);
        apply_stimulus("lw.rd2",   OP_LW, 1'b1, ST_MEM_RD,   C_MEMRD,  1);
        apply_stimulus("lw.wb",    OP_LW, 1'b1, ST_WB_MEM,   C_WBMEM,  1);

        apply_stimulus("beq.fetch", OP_BEQ, 1'b1, ST_FETCH,  C_FETCH,  2);
        apply_stimulus("beq.dec",   OP_BEQ, 1'b1, ST_DECODE, C_DECODE, 2);
        apply_stimulus("beq.br",    OP_BEQ, 1'b1, ST_BRANCH, C_BEQ,    2);

        apply_stimulus("bne.fetch", OP_BNE, 1'b1, ST_FETCH,  C_FETCH,  3);
        apply_stimulus("bne.dec",   OP_BNE, 1'b1, ST_DECODE, C_DECODE, 3);
        apply_stimulus("bne.br",    OP_BEQ, 1'b1, ST_BRANCH, C_BNE,    3);

        apply_stimulus("j.fetch", OP_J, 1'b1, ST_FETCH,  C_FETCH,  4);
        apply_stimulus("j.dec",   OP_J, 1'b1, ST_DECODE, C_DECODE, 4);
        apply_stimulus("j.jump",  OP_J, 1'b1, ST_JUMP,   C_JUMP,   4);

        apply_stimulus("addi.fetch", OP_ADDI, 1'b1, ST_FETCH,   C_FETCH,  5);
        apply_stimulus("addi.dec",   OP_ADDI, 1'b1, ST_DECODE,  C_DECODE, 5);
        apply_stimulus("addi.ex",    OP_ADDI, 1'b1, ST_ADDI_EX, C_ADDIEX, 5);
        apply_stimulus("addi.wb",    OP_ADDI, 1'b1, ST_ADDI_WB, C_ADDIWB, 5);

        apply_stimulus("ill.fwait", OP_BAD, 1'b0, ST_FETCH,   C_FWAIT,  6);
        apply_stimulus("ill.fetch", OP_BAD, 1'b1, ST_FETCH,   C_FETCH,  6);
        apply_stimulus("ill.dec",   OP_BAD, 1'b1, ST_DECODE,  C_DECODE, 6);
        apply_stimulus("ill.trap",  OP_BAD, 1'b1, ST_ILLEGAL, C_ILL,    6);

        apply_stimulus("sw.fetch", OP_SW, 1'b1, ST_FETCH,    C_FETCH,  6);
        apply_stimulus("sw.dec",   OP_SW, 1'b1, ST_DECODE,   C_DECODE, 6);
        apply_stimulus("sw.addr",  OP_SW, 1'b1, ST_MEM_ADDR, C_MADDR,  6);
        apply_stimulus("sw.wr0",   OP_SW, 1'b0, ST_MEM_WR,   C_MEMWR,  6);

        // Still in MEM_WR stalled; drop reset between clock edges.
        MemReady = 1'b0;
        #2;
        rst_n = 1'b0;
        push_expected(ST_RESET, C_NONE, 0);
        #1;
        check_output("sw.async_reset");
        @(negedge clk);
        apply_stimulus("sw.held_reset", OP_SW, 1'b0, ST_RESET, C_NONE, 0);
        rst_n = 1'b1;

        apply_stimulus("sw2.reset", OP_SW, 1'b1, ST_RESET,    C_NONE,   0);
        apply_stimulus("sw2.fetch", OP_SW, 1'b1, ST_FETCH,    C_FETCH,  0);
        apply_stimulus("sw2.dec",   OP_SW, 1'b1, ST_DECODE,   C_DECODE, 0);
        apply_stimulus("sw2.addr",  OP_SW, 1'b1, ST_MEM_ADDR, C_MADDR,  0);
        apply_stimulus("sw2.wr",    OP_SW, 1'b1, ST_MEM_WR,   C_MEMWR,  0);
        apply_stimulus("sw2.done",  OP_R,  1'b1, ST_FETCH,    C_FETCH,  1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
